axi_wr_slv: RTL and testbench



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_wr_slv_if.sv | 34 +++
 rtl/axi_burst_addr_gen.sv | 43 ++++
 rtl/axi_wr_slv.sv | 133 +++++++++++++
 tb/tb_axi_wr_slv.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared types and constants for the AXI4 write-channel slave
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef logic [AXI_ADDR_W-1:0]   addr_t;
    typedef logic [AXI_DATA_W-1:0]   data_t;
    typedef logic [AXI_DATA_W/8-1:0] strb_t;
    typedef logic [2:0]              size_t;
    typedef logic [1:0]              burst_t;

    localparam burst_t     BURST_FIXED = 2'b00;
    localparam burst_t     BURST_INCR  = 2'b01;
    localparam burst_t     BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_wr_slv_if.sv
// rtl/axi_wr_slv_if.sv - AXI4 write address, write data and write response channels
interface axi_wr_slv_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic [7:0]              AWLEN;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;

    modport slave (
        input  AWVALID, AWADDR, AWSIZE, AWBURST, AWLEN,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );

    modport master (
        output AWVALID, AWADDR, AWSIZE, AWBURST, AWLEN,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address and burst config check
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  size_t                 size,
    input  burst_t                burst,
    input  logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  cfg_err
);
    localparam int BSHIFT = $clog2(DATA_WIDTH/8);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] beats;
    logic [ADDR_WIDTH-1:0] wsize;
    logic [ADDR_WIDTH-1:0] lower;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        bytes = ADDR_WIDTH'(1) << size;
        beats = ADDR_WIDTH'(len) + ADDR_WIDTH'(1);
        wsize = bytes * beats;
        lower = start_addr & ~(wsize - ADDR_WIDTH'(1));
        incr  = cur_addr + bytes;

        next_addr = cur_addr;
        case (burst)
            BURST_INCR: next_addr = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            // wrap back to the aligned window base once we step past its top
            BURST_WRAP: next_addr = (incr == lower + wsize) ? lower : incr;
            default:    next_addr = cur_addr;
        endcase

        cfg_err = (size > 3'(BSHIFT))
                | (burst == 2'b11)
                | ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end
endmodule

// File: rtl/axi_wr_slv.sv
// rtl/axi_wr_slv.sv - AXI4 write slave front end; AXI_WLAST_CHECK_EN enables WLAST checking
module axi_wr_slv
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi_wr_slv_if.slave                  axi,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);
    localparam int BSHIFT = $clog2(DATA_WIDTH/8);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    wr_state_t             state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    size_t                 size_r;
    burst_t                burst_r;
    logic [7:0]            len_r;
    logic [7:0]            beat_cnt;
    logic                  err;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cfg_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  beat_oob;
    logic                  suppress;
    logic                  last_cnt;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  beat_err;
    logic                  burst_end;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_addr_gen (
        .cur_addr   (cur_addr),
        .start_addr (start_addr),
        .size       (size_r),
        .burst      (burst_r),
        .len        (len_r),
        .next_addr  (next_addr),
        .cfg_err    (cfg_err)
    );

    assign axi.AWREADY = (state == ST_IDLE);
    assign axi.WREADY  = (state == ST_DATA);
    assign axi.BVALID  = bvalid_r;
    assign axi.BRESP   = bresp_r;

    assign aw_hs    = axi.AWVALID && axi.AWREADY;
    assign w_hs     = axi.WVALID && axi.WREADY;
    assign word_idx = cur_addr >> BSHIFT;
    assign beat_oob = (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
    assign suppress = cfg_err | beat_oob;
    assign last_cnt = (beat_cnt == len_r);

`ifdef AXI_WLAST_CHECK_EN
    // an early WLAST closes the burst; a missing one on the final beat is only flagged
    assign beat_err  = suppress | (last_cnt != axi.WLAST);
    assign burst_end = last_cnt | axi.WLAST;
`else
    assign beat_err  = suppress;
    assign burst_end = last_cnt;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            start_addr <= '0;
            size_r     <= '0;
            burst_r    <= '0;
            len_r      <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        cur_addr   <= axi.AWADDR;
                        start_addr <= axi.AWADDR;
                        size_r     <= axi.AWSIZE;
                        burst_r    <= axi.AWBURST;
                        len_r      <= axi.AWLEN;
                        beat_cnt   <= '0;
                        err        <= 1'b0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        mem_we    <= !suppress;
                        mem_addr  <= word_idx[MEM_AW-1:0];
                        mem_wdata <= axi.WDATA;
                        mem_wstrb <= axi.WSTRB;
                        cur_addr  <= next_addr;
                        beat_cnt  <= beat_cnt + 8'd1;
                        err       <= err | beat_err;
                        if (burst_end) begin
                            bvalid_r <= 1'b1;
                            bresp_r  <= (err | beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (axi.BREADY) begin
                        bvalid_r <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_slv.sv
// tb/tb_axi_wr_slv.sv - table-driven scoreboard bench for axi_wr_slv
module tb_axi_wr_slv;
    import axi_pkg::*;

    localparam int MEM_AW = 10;

    typedef struct packed {
        logic [31:0]          addr;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [7:0]           len;
        logic [3:0][3:0]      strb;
        int                   n_we;
        logic [3:0][MEM_AW-1:0] waddr;
        logic [1:0]           resp;
    } vec_t;

    typedef struct packed {
        logic [MEM_AW-1:0] a;
        logic [31:0]       d;
        logic [3:0]        s;
    } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic               mem_we;
    logic [MEM_AW-1:0]  mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_first = 0;
    int we_last = 0;
    wr_t exp_q[$];
    vec_t vecs[10];

    axi_wr_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_wr_slv #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rstn),
        .axi       (axi),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_we: got write to %0h expected none", mem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(e.a));
                chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e.s));
            end
            we_cnt++;
            if (we_cnt == 1) we_first = cyc;
            we_last = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt,
                           input logic [7:0] ln);
        axi.AWVALID = 1'b1;
        axi.AWADDR  = a;
        axi.AWSIZE  = sz;
        axi.AWBURST = bt;
        axi.AWLEN   = ln;
        for (int k = 0; k < 50 && !axi.AWREADY; k++) tick();
        chk("awready_wait", 64'(axi.AWREADY), 64'd1);
        tick();
        axi.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        axi.WVALID = 1'b1;
        axi.WDATA  = d;
        axi.WSTRB  = s;
        axi.WLAST  = last;
        for (int k = 0; k < 50 && !axi.WREADY; k++) tick();
        chk("wready_wait", 64'(axi.WREADY), 64'd1);
        tick();
    endtask

    task automatic get_b(input logic [1:0] resp, input string name);
        for (int k = 0; k < 50 && !axi.BVALID; k++) tick();
        chk({name, "_bvalid"}, 64'(axi.BVALID), 64'd1);
        chk({name, "_bresp"}, 64'(axi.BRESP), 64'(resp));
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [31:0] d;
        we_cnt = 0;
        send_aw(v.addr, v.size, v.burst, v.len);
        for (int i = 0; i <= int'(v.len); i++) begin
            d = $urandom;
            if (i < v.n_we) exp_q.push_back('{v.waddr[i], d, v.strb[i]});
            send_w(d, v.strb[i], i == int'(v.len));
        end
        axi.WVALID = 1'b0;
        axi.WLAST  = 1'b0;
        get_b(v.resp, name);
        chk({name, "_we_count"}, 64'(we_cnt), 64'(v.n_we));
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        // back-to-back beats must land on consecutive cycles
        if (v.n_we > 1 && v.n_we == int'(v.len) + 1)
            chk({name, "_throughput"}, 64'(we_last - we_first), 64'(v.n_we - 1));
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        vecs[0] = '{32'h10,  3'd2, BURST_INCR,  8'd3, 16'hFFFF, 4, {10'd7, 10'd6, 10'd5, 10'd4}, RESP_OKAY};
        vecs[1] = '{32'h38,  3'd2, BURST_WRAP,  8'd3, 16'hFFFF, 4, {10'hD, 10'hC, 10'hF, 10'hE}, RESP_OKAY};
        vecs[2] = '{32'h20,  3'd2, BURST_FIXED, 8'd2, 16'h0421, 3, {10'd0, 10'd8, 10'd8, 10'd8}, RESP_OKAY};
        vecs[3] = '{32'hFF8, 3'd2, BURST_INCR,  8'd3, 16'hFFFF, 2, {10'd0, 10'd0, 10'h3FF, 10'h3FE}, RESP_SLVERR};
        vecs[4] = '{32'h40,  3'd3, BURST_INCR,  8'd3, 16'hFFFF, 0, 40'd0, RESP_SLVERR};
        vecs[5] = '{32'h40,  3'd2, 2'b11,       8'd0, 16'hFFFF, 0, 40'd0, RESP_SLVERR};
        vecs[6] = '{32'h40,  3'd2, BURST_WRAP,  8'd2, 16'hFFFF, 0, 40'd0, RESP_SLVERR};
        vecs[7] = '{32'h0,   3'd2, BURST_INCR,  8'd0, 16'h0003, 1, 40'd0, RESP_OKAY};
        vecs[8] = '{32'h3,   3'd0, BURST_INCR,  8'd3, 16'h8421, 4, {10'd1, 10'd1, 10'd1, 10'd0}, RESP_OKAY};
        vecs[9] = '{32'h6,   3'd1, BURST_WRAP,  8'd3, 16'hC3C3, 4, {10'd1, 10'd0, 10'd0, 10'd1}, RESP_OKAY};

        axi.AWVALID = 1'b0; axi.AWADDR = '0; axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWLEN = '0;
        axi.WVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.BREADY = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        chk("rst_awready", 64'(axi.AWREADY), 64'd1);
        chk("rst_wready", 64'(axi.WREADY), 64'd0);
        chk("rst_bvalid", 64'(axi.BVALID), 64'd0);
        chk("rst_bresp", 64'(axi.BRESP), 64'd0);
        chk("rst_mem", {31'd0, mem_we, 22'(mem_addr), mem_wstrb}, 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // minimum turnaround: AW at T, W at T+1, B at T+2, AWREADY at T+3
        d = $urandom;
        exp_q.push_back('{10'd16, d, 4'hF});
        axi.AWVALID = 1'b1; axi.AWADDR = 32'h40; axi.AWSIZE = 3'd2;
        axi.AWBURST = BURST_INCR; axi.AWLEN = 8'd0;
        tick();
        axi.AWVALID = 1'b0;
        chk("ta_wready", {62'd0, axi.WREADY, axi.AWREADY}, 64'd2);
        axi.WVALID = 1'b1; axi.WDATA = d; axi.WSTRB = 4'hF; axi.WLAST = 1'b1;
        tick();
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        chk("ta_bvalid", {62'd0, axi.BVALID, axi.WREADY}, 64'd2);
        chk("ta_bresp", 64'(axi.BRESP), 64'(RESP_OKAY));
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
        chk("ta_awready", {62'd0, axi.AWREADY, axi.BVALID}, 64'd2);
        chk("ta_sb_empty", 64'(exp_q.size()), 64'd0);

        // a W beat offered in IDLE waits for the address
        d = $urandom;
        exp_q.push_back('{10'd20, d, 4'h5});
        axi.WVALID = 1'b1; axi.WDATA = d; axi.WSTRB = 4'h5; axi.WLAST = 1'b1;
        tick(); tick();
        chk("stall_wready", 64'(axi.WREADY), 64'd0);
        chk("stall_sb", 64'(exp_q.size()), 64'd1);
        send_aw(32'h50, 3'd2, BURST_INCR, 8'd0);
        send_w(d, 4'h5, 1'b1);
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        get_b(RESP_OKAY, "stall");
        chk("stall_sb_empty", 64'(exp_q.size()), 64'd0);

        // reset after beat 2 of an 8-beat burst abandons it
        send_aw(32'h100, 3'd2, BURST_INCR, 8'd7);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            exp_q.push_back('{10'(64 + i), d, 4'hF});
            send_w(d, 4'hF, 1'b0);
        end
        axi.WVALID = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst_awready", 64'(axi.AWREADY), 64'd1);
        chk("mrst_wready", 64'(axi.WREADY), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mrst_no_bvalid", 64'(axi.BVALID), 64'd0);
        end
        chk("mrst_sb_empty", 64'(exp_q.size()), 64'd0);
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
